memory_writeback: RTL and testbench
===================================

Name: memory_writeback

Overview:
- Pipeline stage directly downstream of the execute stage. It consumes the execute stage's registered bundle: pc, inst, r0data, r1data, result, with valid/ready.
- For loads, it waits for the data-memory read response and byte-aligns and extends it.
- For every instruction, it produces the register-file writeback bundle: rd, data, write enable.
- A load holds the stage in a wait state, with ready_o low, until the response arrives or times out.

Parameters:
- LOAD_TIMEOUT, 255: cycles in WAIT before the load is abandoned. Legal range 1..65535.
- ERR_DATA, 32'hFFFFFFFF: writeback data delivered on a timed-out load.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  upstream bundle valid
- ready_o  out  1  stage can accept the bundle this cycle
- pc_i  in  32  instruction PC
- inst_i  in  32  instruction word
- r0data_i  in  32  rs1 value (load base)
- r1data_i  in  32  rs2 value (unused except passthrough)
- result_i  in  32  ALU/link result from execute
- dmem_rdata_i  in  32  word-aligned read data
- dmem_rvalid_i  in  1  read data valid
- valid_ro  out  1  writeback bundle valid
- ready_i  in  1  downstream accepts bundle
- pc_ro  out  32  registered PC
- inst_ro  out  32  registered instruction
- rd_ro  out  5  destination register, inst[11:7]
- wbdata_ro  out  32  writeback data
- regwrite_ro  out  1  register-file write enable, already qualified with valid
- err_ro  out  1  load timed out (valid with valid_ro)

Behaviour:
- Reset: state=IDLE, timeout counter=0. All outputs 0, including valid_ro, regwrite_ro and err_ro.
- cke = (state==IDLE) & (~valid_ro | ready_i). ready_o = cke.
- States: IDLE, WAIT.
- IDLE, cke, valid_i, non-load:
  - Next edge loads pc/inst/rd from the inputs, wbdata_ro=result_i, valid_ro=1, err_ro=0.
  - regwrite_ro=1 iff opcode in {OP, OPIMM, LUI, AUIPC, JAL, JALR} and rd!=0.
  - Store and branch bundles still pass with regwrite_ro=0.
- IDLE, cke, valid_i=0: valid_ro<=0 and regwrite_ro<=0. Other outputs are don't-care.
- IDLE, cke, valid_i, opcode==LOAD:
  - Capture pc, inst, rd, funct3, and offset=(r0data_i + sext(inst[31:20]))[1:0].
  - valid_ro<=0. Counter<=0. Go to WAIT.
- WAIT: ready_o=0. dmem_rvalid_i is sampled starting the cycle after entry; rvalid in the accept cycle is ignored.
- WAIT, dmem_rvalid_i=1:
  - wbdata_ro = format(dmem_rdata_i), valid_ro=1, err_ro=0, regwrite_ro=(rd!=0). Go to IDLE.
- WAIT, no rvalid, counter==LOAD_TIMEOUT-1:
  - wbdata_ro=ERR_DATA, valid_ro=1, err_ro=1, regwrite_ro=0. Go to IDLE.
  - Otherwise counter+1. The counter is 16 bits and saturating.
- Output is always free while in WAIT, because valid_ro was cleared on entry. No response is ever dropped.
- format():
  - byte = rdata[8*offset +: 8]; half = rdata[16*offset[1] +: 16].
  - LB (000) sign-extends byte. LBU (100) zero-extends byte.
  - LH (001) sign-extends half. LHU (101) zero-extends half.
  - LW (010) returns the whole word.
  - Other funct3 values return ERR_DATA.
  - Misaligned LH/LW uses offset[1] / ignores offset, respectively.
- Stall: while valid_ro & ~ready_i, every registered output holds.
- dmem_rvalid_i in IDLE is ignored.
- Reset mid-WAIT aborts the load and emits nothing.

Optional Feature:
- Macro MEMWB_MISALIGN_TRAP_EN.
- When defined, adds output misalign_ro (1 bit, reset 0), registered with the bundle.
  - LH/LHU with offset[0]=1, or LW with offset!=0, sets misalign_ro=1.
  - Such a load is not sent to WAIT. It completes the next edge with regwrite_ro=0, wbdata_ro=ERR_DATA, valid_ro=1.
- When undefined, the port is absent and misaligned loads are formatted as above.

Test Plan:
- ADDI x5 (result_i=32'h0000002A), ready_i=1 -> next cycle: valid_ro=1, rd_ro=5, wbdata_ro=32'h2A, regwrite_ro=1, err_ro=0.
- LB x7, r0data_i=32'h1001, imm=2 (offset 3); rvalid 3 cycles later with rdata=32'h80FF1234:
  - ready_o=0 for 3 cycles.
  - Then wbdata_ro=32'hFFFFFF80, regwrite_ro=1.
  - ready_o returns to 1 the cycle after.
- LHU x3 at offset 2, rdata=32'hBEEF0000, immediate rvalid -> wbdata_ro=32'h0000BEEF. A second LHU to x0 -> regwrite_ro=0.
- LW with LOAD_TIMEOUT=4 and no rvalid -> after 4 WAIT cycles: valid_ro=1, err_ro=1, wbdata_ro=32'hFFFFFFFF, regwrite_ro=0. A later stray rvalid in IDLE is ignored.
- ADD result 32'h5 with ready_i=0 for 3 cycles -> outputs held, ready_o=0; the next valid_i bundle is accepted only after ready_i=1.
- rst pulsed during WAIT, then rvalid -> valid_ro stays 0 and state is IDLE. With MEMWB_MISALIGN_TRAP_EN, LW at offset 1 -> misalign_ro=1 the next cycle, no WAIT.

Source files
------------

// File: rtl/memory_writeback.sv
// Memory/writeback stage: waits for load responses, byte-aligns/extends them and emits the writeback bundle.
// Optional MEMWB_MISALIGN_TRAP_EN adds misalign_ro and completes misaligned LH/LHU/LW without a memory wait.
module memory_writeback #(
    parameter int unsigned LOAD_TIMEOUT = 255,
    parameter logic [31:0] ERR_DATA     = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] r0data_i,
    input  logic [31:0] r1data_i,
    input  logic [31:0] result_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_rvalid_i,
    output logic        valid_ro,
    input  logic        ready_i,
    output logic [31:0] pc_ro,
    output logic [31:0] inst_ro,
    output logic [4:0]  rd_ro,
    output logic [31:0] wbdata_ro,
    output logic        regwrite_ro,
`ifdef MEMWB_MISALIGN_TRAP_EN
    output logic        misalign_ro,
`endif
    output logic        err_ro
);
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOAD_TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, wbdata_q, wbdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic        valid_q, valid_d, regwrite_q, regwrite_d, err_q, err_d;
    logic        cke, writes_rd, trap_load;
    logic [6:0]  opcode;
    logic [31:0] addr;
    logic        unused_ok;

    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> {off, 3'b000});
        h = 16'(rdata >> {off[1], 4'b0000});
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            3'b010:  return rdata;
            default: return ERR_DATA;
        endcase
    endfunction

    assign opcode    = inst_i[6:0];
    assign addr      = r0data_i + {{20{inst_i[31]}}, inst_i[31:20]};
    assign writes_rd = (opcode inside {OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR})
                       && (inst_i[11:7] != 5'd0);
    assign cke       = (state_q == IDLE) && (!valid_q || ready_i);
    assign ready_o   = cke;
    assign unused_ok = ^{r1data_i, addr[31:2]};

`ifdef MEMWB_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign trap_load = ((inst_i[13:12] == 2'b01) && addr[0])
                       || ((inst_i[14:12] == 3'b010) && (addr[1:0] != 2'b00));
    assign misalign_ro = misalign_q;
`else
    assign trap_load = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        offset_d   = offset_q;
        wbdata_d   = wbdata_q;
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        err_d      = err_q;
`ifdef MEMWB_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                if (cke) begin
                    valid_d    = 1'b0;
                    regwrite_d = 1'b0;
                    if (valid_i) begin
                        pc_d   = pc_i;
                        inst_d = inst_i;
                        rd_d   = inst_i[11:7];
                        err_d  = 1'b0;
`ifdef MEMWB_MISALIGN_TRAP_EN
                        misalign_d = (opcode == OPC_LOAD) && trap_load;
`endif
                        if (opcode != OPC_LOAD) begin
                            valid_d    = 1'b1;
                            wbdata_d   = result_i;
                            regwrite_d = writes_rd;
                        end else if (trap_load) begin
                            valid_d  = 1'b1;
                            wbdata_d = ERR_DATA;
                        end else begin
                            funct3_d = inst_i[14:12];
                            offset_d = addr[1:0];
                            cnt_d    = 16'd0;
                            state_d  = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                // Output is always free here because valid was cleared on entry.
                if (dmem_rvalid_i) begin
                    wbdata_d   = format_load(funct3_q, offset_q, dmem_rdata_i);
                    valid_d    = 1'b1;
                    err_d      = 1'b0;
                    regwrite_d = (rd_q != 5'd0);
                    state_d    = IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    wbdata_d   = ERR_DATA;
                    valid_d    = 1'b1;
                    err_d      = 1'b1;
                    regwrite_d = 1'b0;
                    state_d    = IDLE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pc_q       <= '0;
            inst_q     <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            offset_q   <= '0;
            wbdata_q   <= '0;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef MEMWB_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            offset_q   <= offset_d;
            wbdata_q   <= wbdata_d;
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            err_q      <= err_d;
`ifdef MEMWB_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign valid_ro    = valid_q;
    assign pc_ro       = pc_q;
    assign inst_ro     = inst_q;
    assign rd_ro       = rd_q;
    assign wbdata_ro   = wbdata_q;
    assign regwrite_ro = regwrite_q;
    assign err_ro      = err_q;

endmodule

// File: tb/tb_memory_writeback.sv
// Self-checking bench for memory_writeback: directed scenarios plus randomized traffic against a behavioural model.
// Honours MEMWB_MISALIGN_TRAP_EN the same way the design does.
module tb_memory_writeback;
    localparam int unsigned TO      = 4;
    localparam logic [31:0] ERR     = 32'hFFFF_FFFF;
    localparam logic [6:0]  LOAD    = 7'b0000011;
    localparam logic [6:0]  OPIMM   = 7'b0010011;
    localparam logic [6:0]  AUIPC   = 7'b0010111;
    localparam logic [6:0]  STORE   = 7'b0100011;
    localparam logic [6:0]  OP      = 7'b0110011;
    localparam logic [6:0]  LUI     = 7'b0110111;
    localparam logic [6:0]  BRANCH  = 7'b1100011;
    localparam logic [6:0]  JALR    = 7'b1100111;
    localparam logic [6:0]  JAL     = 7'b1101111;
    localparam logic [6:0]  SYSTEM  = 7'b1110011;
`ifdef MEMWB_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, rst, valid_i, ready_o, dmem_rvalid_i, valid_ro, ready_i, regwrite_ro, err_ro;
    logic [31:0] pc_i, inst_i, r0data_i, r1data_i, result_i, dmem_rdata_i, pc_ro, inst_ro, wbdata_ro;
    logic [4:0]  rd_ro;
    logic        misalign_obs;
    int          checks = 0;
    int          errors = 0;

    memory_writeback #(.LOAD_TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .r0data_i(r0data_i), .r1data_i(r1data_i),
        .result_i(result_i), .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i),
        .valid_ro(valid_ro), .ready_i(ready_i), .pc_ro(pc_ro), .inst_ro(inst_ro),
        .rd_ro(rd_ro), .wbdata_ro(wbdata_ro), .regwrite_ro(regwrite_ro),
`ifdef MEMWB_MISALIGN_TRAP_EN
        .misalign_ro(misalign_obs),
`endif
        .err_ro(err_ro)
    );
`ifndef MEMWB_MISALIGN_TRAP_EN
    assign misalign_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    // Reference load formatting with plain integer arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        int bv, hv;
        bv = int'((w >> (8 * off)) & 32'hFF);
        hv = int'((w >> ((off >= 2) ? 16 : 0)) & 32'hFFFF);
        case (f3)
            3'd0:    return 32'(bv >= 128 ? bv - 256 : bv);
            3'd4:    return 32'(bv);
            3'd1:    return 32'(hv >= 32768 ? hv - 65536 : hv);
            3'd5:    return 32'(hv);
            3'd2:    return w;
            default: return ERR;
        endcase
    endfunction

    // Issue one bundle with ready_i=1; lat = WAIT cycles before rvalid (>=TO means never).
    task automatic run_one(input string name, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] r0, input logic [31:0] res,
                           input logic [31:0] rdata, input int lat);
        logic [31:0] addr, exp_data;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        int          off, n, exp_wait;
        bit          exp_reg, exp_err, exp_mis, is_load;
        op   = inst[6:0];
        f3   = inst[14:12];
        rd   = inst[11:7];
        addr = r0 + {{20{inst[31]}}, inst[31:20]};
        off  = int'(addr % 4);
        is_load = (op == LOAD);
        exp_mis = TRAP && is_load && (((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) ||
                                      (f3 == 3'd2 && off != 0));
        exp_err = 1'b0;
        if (!is_load) begin
            exp_wait = 0; exp_data = res;
            exp_reg  = (op == OP || op == OPIMM || op == LUI || op == AUIPC || op == JAL || op == JALR) && rd != 0;
        end else if (exp_mis) begin
            exp_wait = 0; exp_data = ERR; exp_reg = 1'b0;
        end else if (lat < int'(TO)) begin
            exp_wait = lat + 1; exp_data = ref_load(f3, off, rdata); exp_reg = (rd != 0);
        end else begin
            exp_wait = int'(TO); exp_data = ERR; exp_reg = 1'b0; exp_err = 1'b1;
        end
        ready_i = 1'b1; valid_i = 1'b1; pc_i = pc; inst_i = inst; r0data_i = r0;
        r1data_i = $urandom(); result_i = res;
        dmem_rvalid_i = 1'($urandom_range(0, 1));
        dmem_rdata_i = ~rdata;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL %s accept ready_o: got %b expected 1", name, ready_o); end
        step();
        valid_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = rdata;
        n = 0;
        while (valid_ro !== 1'b1 && n < int'(TO) + 3) begin
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL %s wait ready_o: got %b expected 0", name, ready_o); end
            dmem_rvalid_i = (n == lat);
            step();
            n++;
        end
        dmem_rvalid_i = 1'b0;
        checks++; if (n != exp_wait) begin errors++; $display("FAIL %s wait_cycles: got %0d expected %0d", name, n, exp_wait); end
        checks++; if (valid_ro !== 1'b1) begin errors++; $display("FAIL %s valid_ro: got %b expected 1", name, valid_ro); end
        checks++; if (wbdata_ro !== exp_data) begin errors++; $display("FAIL %s wbdata_ro: got %h expected %h", name, wbdata_ro, exp_data); end
        checks++; if (regwrite_ro !== exp_reg) begin errors++; $display("FAIL %s regwrite_ro: got %b expected %b", name, regwrite_ro, exp_reg); end
        checks++; if (err_ro !== exp_err) begin errors++; $display("FAIL %s err_ro: got %b expected %b", name, err_ro, exp_err); end
        checks++; if (misalign_obs !== exp_mis) begin errors++; $display("FAIL %s misalign_ro: got %b expected %b", name, misalign_obs, exp_mis); end
        checks++; if ({pc_ro, inst_ro, rd_ro} !== {pc, inst, rd}) begin errors++;
            $display("FAIL %s pc/inst/rd: got %h %h %0d expected %h %h %0d", name, pc_ro, inst_ro, rd_ro, pc, inst, rd); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL %s ready_o after done: got %b expected 1", name, ready_o); end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; pc_i = '0; inst_i = '0; r0data_i = '0;
        r1data_i = '0; result_i = '0; dmem_rdata_i = '0; dmem_rvalid_i = 1'b0;
        #12;
        checks++; if ({valid_ro, regwrite_ro, err_ro, misalign_obs} !== 4'b0) begin errors++;
            $display("FAIL reset flags: got %b expected 0000", {valid_ro, regwrite_ro, err_ro, misalign_obs}); end
        checks++; if ({pc_ro, inst_ro, rd_ro, wbdata_ro} !== '0) begin errors++;
            $display("FAIL reset data: got %h %h %h %h expected 0", pc_ro, inst_ro, rd_ro, wbdata_ro); end
        rst = 1'b0;
        step();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset ready_o: got %b expected 1", ready_o); end
    endtask

    task automatic test_directed();
        run_one("addi_x5", 32'h100, mk(12'd42, 5'd1, 3'd0, 5'd5, OPIMM), 32'h0, 32'h2A, 32'h0, 0);
        run_one("lb_x7", 32'h104, mk(12'd2, 5'd2, 3'd0, 5'd7, LOAD), 32'h1001, 32'h0, 32'h80FF1234, 2);
        run_one("lhu_x3", 32'h108, mk(12'd2, 5'd2, 3'd5, 5'd3, LOAD), 32'h2000, 32'h0, 32'hBEEF0000, 0);
        run_one("lhu_x0", 32'h10C, mk(12'd2, 5'd2, 3'd5, 5'd0, LOAD), 32'h2000, 32'h0, 32'hBEEF0000, 0);
        run_one("sw", 32'h110, mk(12'd4, 5'd2, 3'd2, 5'd9, STORE), 32'h0, 32'h55, 32'h0, 0);
        run_one("beq", 32'h114, mk(12'd8, 5'd2, 3'd0, 5'd1, BRANCH), 32'h0, 32'h66, 32'h0, 0);
        run_one("lw_timeout", 32'h118, mk(12'd0, 5'd2, 3'd2, 5'd9, LOAD), 32'h3000, 32'h0, 32'h12345678, 99);
        valid_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
        step();
        dmem_rvalid_i = 1'b0;
        checks++; if (valid_ro !== 1'b0) begin errors++; $display("FAIL stray_rvalid valid_ro: got %b expected 0", valid_ro); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stray_rvalid ready_o: got %b expected 1", ready_o); end
    endtask

    task automatic test_stall();
        run_one("add_stall", 32'h200, mk(12'd0, 5'd1, 3'd0, 5'd4, OP), 32'h0, 32'h5, 32'h0, 0);
        ready_i = 1'b0; valid_i = 1'b1; pc_i = 32'h204; inst_i = mk(12'd9, 5'd0, 3'd0, 5'd6, OPIMM); result_i = 32'h9;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stall ready_o: got %b expected 0", ready_o); end
            step();
            checks++; if ({valid_ro, wbdata_ro, rd_ro, pc_ro} !== {1'b1, 32'h5, 5'd4, 32'h200}) begin errors++;
                $display("FAIL stall hold: got %b %h %0d %h expected 1 00000005 4 00000200", valid_ro, wbdata_ro, rd_ro, pc_ro); end
        end
        ready_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stall release ready_o: got %b expected 1", ready_o); end
        step();
        valid_i = 1'b0;
        checks++; if ({valid_ro, wbdata_ro, rd_ro, regwrite_ro} !== {1'b1, 32'h9, 5'd6, 1'b1}) begin errors++;
            $display("FAIL stall next: got %b %h %0d %b expected 1 00000009 6 1", valid_ro, wbdata_ro, rd_ro, regwrite_ro); end
    endtask

    task automatic test_reset_mid_wait();
        ready_i = 1'b1; valid_i = 1'b1; pc_i = 32'h300; inst_i = mk(12'd0, 5'd2, 3'd2, 5'd8, LOAD); r0data_i = 32'h4000;
        #1;
        step();
        valid_i = 1'b0;
        step();
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL midwait ready_o before rst: got %b expected 0", ready_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({valid_ro, ready_o} !== 2'b01) begin errors++; $display("FAIL midwait in rst: got %b expected 01", {valid_ro, ready_o}); end
        rst = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h11112222;
        step();
        dmem_rvalid_i = 1'b0;
        checks++; if ({valid_ro, regwrite_ro, ready_o} !== 3'b001) begin errors++;
            $display("FAIL midwait after rvalid: got %b expected 001", {valid_ro, regwrite_ro, ready_o}); end
    endtask

    task automatic test_misalign();
        run_one("lw_off1", 32'h400, mk(12'd1, 5'd2, 3'd2, 5'd10, LOAD), 32'h5000, 32'h0, 32'hA5A5A5A5, 0);
        run_one("lh_off3", 32'h404, mk(12'd3, 5'd2, 3'd1, 5'd11, LOAD), 32'h5000, 32'h0, 32'h8001C002, 1);
    endtask

    task automatic test_random();
        logic [31:0] r, pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        pc = 32'h1000;
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            case ($urandom_range(0, 12))
                0, 1, 2, 3: op = LOAD;
                4:  op = OP;     5:  op = OPIMM;  6: op = LUI;    7: op = AUIPC;
                8:  op = JAL;    9:  op = JALR;   10: op = STORE; 11: op = BRANCH;
                default: op = SYSTEM;
            endcase
            f3 = (op == LOAD) ? 3'($urandom_range(0, 7)) : r[14:12];
            run_one($sformatf("rand%0d", i), pc, {r[31:15], f3, r[11:7], op}, $urandom(), $urandom(),
                    $urandom(), int'($urandom_range(0, 5)));
            pc += 4;
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                step();
                checks++; if ({valid_ro, regwrite_ro} !== 2'b00) begin errors++;
                    $display("FAIL rand%0d bubble: got %b expected 00", i, {valid_ro, regwrite_ro}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_wait();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
